// File: rtl/multicycle_control.sv
`default_nettype none
//============================================================================
// Module   : multicycle_control
// Purpose  : Registered control sequencer for a multicycle RV32I datapath.
//            Walks each instruction through FETCH / DECODE / EXECUTE /
//            MEMORY / WRITEBACK states and drives the datapath selects,
//            the ALU operation and all write enables. Adds memory
//            wait-state handling, illegal-instruction detection and a
//            retired-instruction counter.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            op, funct3, funct7b5 - instruction fields from the IR
//            zero                 - ALU zero flag (branch resolution)
//            mem_ready            - memory access completes this cycle
//            ALUSrcA/ALUSrcB      - ALU operand selects
//            ALUCtr               - ALU operation code
//            ResultSrc, AdrSrc    - result / address selects
//            PCWrite, IRWrite,
//            RegWrite, MemWrite   - datapath write enables
//            illegal              - one-cycle unsupported-instruction pulse
//            state                - current state (debug)
//            instret              - retired-instruction count
// Revision : 1.0 - initial release
//============================================================================
module multicycle_control #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MEM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUCtr,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    // State encoding
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             w_rdy;
    logic [3:0]       w_alu_fn;
    logic [1:0]       w_srca, w_srcb, w_res;
    logic [3:0]       w_alu;
    logic             w_adr, w_pcw, w_irw, w_regw, w_memw, w_ill, w_retire;

    // With wait states disabled every memory access completes immediately.
    assign w_rdy = (WAIT_MEM != 0) ? mem_ready : 1'b1;

    // Register/immediate ALU decode. funct7b5 selects sub only for R-type;
    // for I-type bit 30 is part of the immediate except on shifts.
    always_comb begin
        w_alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_fn = (funct7b5 && (state_q == S_EXECR)) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_fn = ALU_SLL;
            3'b010:  w_alu_fn = ALU_SLT;
            3'b011:  w_alu_fn = ALU_SLTU;
            3'b100:  w_alu_fn = ALU_XOR;
            3'b101:  w_alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d  = state_q;
        w_srca   = 2'b00;
        w_srcb   = 2'b00;
        w_alu    = ALU_ADD;
        w_res    = 2'b00;
        w_adr    = 1'b0;
        w_pcw    = 1'b0;
        w_irw    = 1'b0;
        w_regw   = 1'b0;
        w_memw   = 1'b0;
        w_ill    = 1'b0;
        w_retire = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_srcb = 2'b10;
                w_res  = 2'b10;
                w_irw  = w_rdy;
                w_pcw  = w_rdy;
                if (w_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm: branch target is ready in ALUOut for BRANCH
                w_srca = 2'b01;
                w_srcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        w_ill   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_srca  = 2'b10;
                w_srcb  = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr = 1'b1;
                if (w_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_res    = 2'b01;
                w_regw   = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr  = 1'b1;
                w_memw = 1'b1;
                if (w_rdy) begin
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                w_srca  = 2'b10;
                w_alu   = w_alu_fn;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                w_srca  = 2'b10;
                w_srcb  = 2'b01;
                w_alu   = w_alu_fn;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw   = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                w_srca  = 2'b10;
                w_alu   = ALU_SUB;
                state_d = S_FETCH;
                case (funct3)
                    3'b000: begin
                        w_pcw    = zero;
                        w_retire = 1'b1;
                    end
                    3'b001: begin
                        w_pcw    = ~zero;
                        w_retire = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            S_JAL: begin
                w_srca  = 2'b01;
                w_srcb  = 2'b10;
                w_pcw   = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = w_retire ? (instret_q + CNT_ONE) : instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Write enables and illegal are suppressed while reset is held so an
    // abandoned instruction cannot modify architectural state.
    assign ALUSrcA   = w_srca;
    assign ALUSrcB   = w_srcb;
    assign ALUCtr    = w_alu;
    assign ResultSrc = w_res;
    assign AdrSrc    = w_adr;
    assign PCWrite   = w_pcw  & ~reset;
    assign IRWrite   = w_irw  & ~reset;
    assign RegWrite  = w_regw & ~reset;
    assign MemWrite  = w_memw & ~reset;
    assign illegal   = w_ill  & ~reset;
    assign state     = state_q;
    assign instret   = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
//============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. Each instruction
//            is expanded into its expected state walk from its class and
//            the wait cycles applied; every cycle the state, write enables,
//            selects and instret are compared with that reference.
// Revision : 1.0 - initial release
//============================================================================
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam int MODC  = 16;

    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7b5 = 1'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]       ALUCtr, state;
    logic             AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, illegal;
    logic [CNT_W-1:0] instret;

    int total = 0;
    int bad = 0;
    int exp_instret = 0;

    // Per-state select values, indexed by state code 0..10.
    int t_srca [0:10] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 2, 1};
    int t_srcb [0:10] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2};
    int t_res  [0:10] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int t_adr  [0:10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    multicycle_control #(.CNT_W(CNT_W), .WAIT_MEM(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUCtr(ALUCtr), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic bit legal_op(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
    endfunction

    // Runs one instruction. fw/mw = wait cycles in FETCH / memory state,
    // zv = forced zero flag (-1 random), abort_at = cycle index at which
    // reset is raised (-1 never).
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic f7,
                             input int zv, input int fw, input int mw, input int abort_at);
        int seq[$];
        int rdy[$];
        bit retires;
        int st;
        logic [4:0]  e_en;
        logic [10:0] e_sel;
        logic [3:0]  e_alu;
        for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(0); end
        seq.push_back(0); rdy.push_back(1);
        seq.push_back(1); rdy.push_back(2);
        case (iop)
            LW: begin
                seq.push_back(2); rdy.push_back(2);
                for (int i = 0; i < mw; i++) begin seq.push_back(3); rdy.push_back(0); end
                seq.push_back(3); rdy.push_back(1);
                seq.push_back(4); rdy.push_back(2);
            end
            SW: begin
                seq.push_back(2); rdy.push_back(2);
                for (int i = 0; i < mw; i++) begin seq.push_back(5); rdy.push_back(0); end
                seq.push_back(5); rdy.push_back(1);
            end
            RT: begin seq.push_back(6); rdy.push_back(2); seq.push_back(8); rdy.push_back(2); end
            IT: begin seq.push_back(7); rdy.push_back(2); seq.push_back(8); rdy.push_back(2); end
            BR: begin seq.push_back(9); rdy.push_back(2); end
            JL: begin seq.push_back(10); rdy.push_back(2); seq.push_back(8); rdy.push_back(2); end
            default: ;
        endcase
        retires = legal_op(iop) && !(iop == BR && f3 > 3'd1);

        for (int i = 0; i < seq.size(); i++) begin
            st = seq[i];
            op = iop; funct3 = f3; funct7b5 = f7;
            zero = (zv < 0) ? 1'($urandom_range(0, 1)) : (zv != 0);
            mem_ready = (rdy[i] == 2) ? 1'($urandom_range(0, 1)) : (rdy[i] != 0);
            if (i == abort_at) reset = 1'b1;
            @(negedge clk);
            // {PCWrite, IRWrite, RegWrite, MemWrite, illegal}
            e_en[4] = (st == 0 && mem_ready) || (st == 10) ||
                      (st == 9 && ((f3 == 3'd0 && zero) || (f3 == 3'd1 && !zero)));
            e_en[3] = (st == 0 && mem_ready);
            e_en[2] = (st == 4 || st == 8);
            e_en[1] = (st == 5);
            e_en[0] = (st == 1 && !legal_op(iop)) || (st == 9 && f3 > 3'd1);
            if (reset) e_en = '0;
            e_alu = (st == 6) ? exp_alu(1'b1, f3, f7) :
                    (st == 7) ? exp_alu(1'b0, f3, f7) :
                    (st == 9) ? 4'd1 : 4'd0;
            e_sel = {2'(t_srca[st]), 2'(t_srcb[st]), e_alu, 2'(t_res[st]), 1'(t_adr[st])};

            total++;
            if (state !== 4'(st)) begin
                bad++;
                $display("FAIL state op=%b cyc=%0d: got %0d expected %0d", iop, i, state, st);
            end
            total++;
            if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== e_en) begin
                bad++;
                $display("FAIL enables op=%b st=%0d: got %b expected %b", iop, st,
                         {PCWrite, IRWrite, RegWrite, MemWrite, illegal}, e_en);
            end
            total++;
            if ({ALUSrcA, ALUSrcB, ALUCtr, ResultSrc, AdrSrc} !== e_sel) begin
                bad++;
                $display("FAIL selects op=%b f3=%0d st=%0d: got %b expected %b", iop, f3, st,
                         {ALUSrcA, ALUSrcB, ALUCtr, ResultSrc, AdrSrc}, e_sel);
            end
            total++;
            if (instret !== CNT_W'(exp_instret)) begin
                bad++;
                $display("FAIL instret st=%0d: got %0d expected %0d", st, instret, exp_instret);
            end
            @(posedge clk); #1;
            if (i == abort_at) begin
                exp_instret = 0;
                return;
            end
        end
        if (retires) exp_instret = (exp_instret + 1) % MODC;
    endtask

    // One FETCH stall cycle used to observe the state/counter between tests.
    task automatic stall_check(input string name, input int want_cnt);
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 4'd0 || instret !== CNT_W'(want_cnt)) begin
            bad++;
            $display("FAIL %s: got state=%0d instret=%0d expected state=0 instret=%0d",
                     name, state, instret, want_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; op = LW; mem_ready = 1'b1; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (state !== 4'd0 || instret !== '0) begin
            bad++;
            $display("FAIL reset_state: got state=%0d instret=%0d expected 0/0", state, instret);
        end
        total++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== 5'b0) begin
            bad++;
            $display("FAIL reset_enables: got %b expected 00000",
                     {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instret = 0;
    endtask

    task automatic test_lw;
        run_instr(LW, 3'b010, 1'b0, -1, 0, 0, -1);
        stall_check("lw_retired", 1);
    endtask

    task automatic test_add_sub;
        run_instr(RT, 3'b000, 1'b0, -1, 0, 0, -1);
        run_instr(RT, 3'b000, 1'b1, -1, 0, 0, -1);
        stall_check("add_sub_retired", 3);
    endtask

    task automatic test_branch;
        run_instr(BR, 3'b000, 1'b0, 1, 0, 0, -1);
        run_instr(BR, 3'b001, 1'b0, 1, 0, 0, -1);
        run_instr(BR, 3'b100, 1'b0, 0, 0, 0, -1);
        stall_check("branch_retired", 5);
    endtask

    task automatic test_sw_wait;
        run_instr(SW, 3'b010, 1'b0, -1, 1, 3, -1);
        stall_check("sw_wait_retired", 6);
    endtask

    task automatic test_illegal;
        run_instr(7'b1111111, 3'b000, 1'b0, -1, 0, 0, -1);
        stall_check("illegal_not_counted", 6);
    endtask

    task automatic test_random;
        logic [6:0] ops [0:8];
        ops = '{LW, SW, RT, IT, BR, JL, 7'b1111111, 7'b0110111, 7'b0000000};
        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), -1, $urandom_range(0, 2),
                      $urandom_range(0, 2), -1);
        end
        stall_check("random_count", exp_instret);
    endtask

    task automatic test_wrap;
        while (exp_instret != 15)
            run_instr(IT, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, 0, 0, -1);
        stall_check("wrap_preload", 15);
        run_instr(JL, 3'b000, 1'b0, -1, 0, 0, -1);
        stall_check("wrap_to_zero", 0);
    endtask

    task automatic test_reset_mid;
        run_instr(RT, 3'b111, 1'b0, -1, 0, 0, -1);
        // Walk 0,1,2,3(wait),3(wait): reset raised on the second MEMREAD cycle.
        run_instr(LW, 3'b010, 1'b0, -1, 0, 2, 4);
        @(negedge clk);
        total++;
        if (state !== 4'd0 || instret !== '0) begin
            bad++;
            $display("FAIL reset_mid: got state=%0d instret=%0d expected 0/0", state, instret);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(RT, 3'b110, 1'b0, -1, 0, 0, -1);
        stall_check("after_reset_mid", 1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_add_sub();
        test_branch();
        test_sw_wait();
        test_illegal();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Registered control sequencer for the multicycle RV32I datapath. It steps one instruction at a time through fetch, decode, execute, memory and writeback states. In each state it drives the ALU operand selects (ALUSrcA, ALUSrcB), the ALU operation code (ALUCtr), and all datapath write enables. It adds three things to a purely combinational ALU decode: memory wait-state handling, illegal-instruction detection and a retired-instruction counter. It sits between the instruction register and the datapath/memory interface.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `WAIT_MEM`, default 1: when 1, the memory states hold until `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode bits [6:0] of the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `ALUSrcA` out 2: operand A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: operand B select. 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUCtr` out 4: ALU operation. 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 sltu.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `AdrSrc` out 1: address select. 0 = PC, 1 = ALUOut.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: datapath write enables.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state encoding, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10.
- Outputs are a combinational function of `state`, `op`, `funct3`, `funct7b5`, `zero` and `mem_ready`. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, A=00, B=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Goes to DECODE on mem_ready, otherwise stays.
- DECODE: A=01, B=01, add (computes branch target). Next state by opcode:
  - lw 0000011 or sw 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH with `illegal`=1
- MEMADR: A=10, B=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, otherwise stays.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Goes to FETCH on mem_ready.
- EXECR: A=10, B=00. ALUCtr by funct3:
  - 000 → funct7b5 ? sub : add
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101 → funct7b5 ? sra : srl
  - 110 or, 111 and
  - Goes to ALUWB.
- EXECI: A=10, B=01. ALUCtr decodes as EXECR, except funct3=000 is always add. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00.
  - funct3=000 (beq): PCWrite=zero.
  - funct3=001 (bne): PCWrite=!zero.
  - any other funct3: PCWrite=0 and `illegal`=1.
  - Goes to FETCH.
- JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
- `instret` increments by 1 on each transition into FETCH that retires an instruction: from MEMWB, from ALUWB, from MEMWRITE on mem_ready, and from BRANCH when not illegal.
  - `instret` does not increment on an illegal exit.
  - `instret` wraps modulo 2^CNT_W.

## Timing
- Reset, when sampled high at an edge, sets state=FETCH and instret=0.
- While reset is high, all write enables and `illegal` are forced to 0. This holds even mid-instruction; the in-flight instruction is abandoned and not counted.
- First FETCH cycle is the cycle after reset deasserts.
- Zero-wait latency, in cycles: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4. Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `illegal` is asserted in the same cycle as the DECODE or BRANCH state that detects it.
- A transition into FETCH and the instret increment take effect on the same edge.

## Test plan
- Reset with WAIT_MEM=1, mem_ready=1, lw (op=0000011) → state sequence 0,1,2,3,4,0. RegWrite only in state 4. instret=1.
- add then sub (op=0110011, funct3=000, funct7b5=0 then 1) → ALUCtr=0 then 1 in EXECR, A=10, B=00, each instruction 4 cycles, instret=2.
- beq with zero=1, then bne with zero=1 → PCWrite=1 in BRANCH for beq, 0 for bne. 3 cycles each.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite held 4 cycles, state stays 5, leaves to FETCH on the cycle mem_ready rises.
- op=1111111 → illegal pulses 1 cycle in DECODE, next state FETCH, instret unchanged.
- CNT_W=4, preloaded by retiring 15 instructions, one more retire → instret=0. Reset asserted in MEMREAD → state 0, instret 0 next cycle.
